// File: rtl/obstacle_anim_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : obstacle_anim_ctrl
// Description : Erase/step/redraw sequencer for one scrolling obstacle sprite,
//               driving the VGA adapter pixel-write port one pixel per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module obstacle_anim_ctrl #(
    parameter int          OBJ_W      = 4,
    parameter int          OBJ_H      = 8,
    parameter int          SCREEN_W   = 160,
    parameter int          Y_MAX      = 112,
    parameter int          STEP       = 1,
    parameter logic [2:0]  OBJ_COLOUR = 3'b010,
    parameter logic [2:0]  BG_COLOUR  = 3'b000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       go,
    input  logic       frame_tick,
    input  logic [6:0] spawn_y,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic [7:0] obj_x,
    output logic [6:0] obj_y,
    output logic       busy,
    output logic       wrapped
);

    localparam int CX_W = (OBJ_W > 1) ? $clog2(OBJ_W) : 1;
    localparam int CY_W = (OBJ_H > 1) ? $clog2(OBJ_H) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SPAWN = 3'd1;
    localparam logic [2:0] DRAW  = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] ERASE = 3'd4;
    localparam logic [2:0] MOVE  = 3'd5;

    localparam logic [7:0]      c_SPAWN_X = 8'(SCREEN_W - OBJ_W);
    localparam logic [6:0]      c_Y_MAX   = 7'(Y_MAX);
    localparam logic [7:0]      c_STEP    = 8'(STEP);
    localparam logic [CX_W-1:0] c_CX_LAST = CX_W'(OBJ_W - 1);
    localparam logic [CY_W-1:0] c_CY_LAST = CY_W'(OBJ_H - 1);

    logic [2:0]      r_state;
    logic [CX_W-1:0] r_cx;
    logic [CY_W-1:0] r_cy;
    logic [7:0]      r_obj_x;
    logic [6:0]      r_obj_y;

    logic w_pixel;
    logic w_last;

    assign w_pixel = (r_state == DRAW) || (r_state == ERASE);
    assign w_last  = (r_cx == c_CX_LAST) && (r_cy == c_CY_LAST);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_cx    <= '0;
            r_cy    <= '0;
            r_obj_x <= '0;
            r_obj_y <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (go) r_state <= SPAWN;
                end
                SPAWN: begin
                    r_obj_x <= c_SPAWN_X;
                    r_obj_y <= (spawn_y > c_Y_MAX) ? c_Y_MAX : spawn_y;
                    r_cx    <= '0;
                    r_cy    <= '0;
                    r_state <= DRAW;
                end
                DRAW, ERASE: begin
                    if (w_last) begin
                        r_cx    <= '0;
                        r_cy    <= '0;
                        r_state <= (r_state == DRAW) ? WAIT : MOVE;
                    end else if (r_cx == c_CX_LAST) begin
                        r_cx <= '0;
                        r_cy <= r_cy + 1'b1;
                    end else begin
                        r_cx <= r_cx + 1'b1;
                    end
                end
                WAIT: begin
                    // go low wins over a coincident tick
                    if (!go)             r_state <= IDLE;
                    else if (frame_tick) r_state <= ERASE;
                end
                MOVE: begin
                    if (r_obj_x < c_STEP) begin
                        r_state <= SPAWN;
                    end else begin
                        r_obj_x <= r_obj_x - c_STEP;
                        r_state <= DRAW;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Moore-decoded pixel port; zeroed whenever no pixel is being written
    assign plot    = w_pixel;
    assign x       = w_pixel ? (r_obj_x + 8'(r_cx)) : 8'd0;
    assign y       = w_pixel ? (r_obj_y + 7'(r_cy)) : 7'd0;
    assign colour  = (r_state == DRAW)  ? OBJ_COLOUR :
                     (r_state == ERASE) ? BG_COLOUR  : 3'd0;
    assign obj_x   = r_obj_x;
    assign obj_y   = r_obj_y;
    assign busy    = (r_state == SPAWN) || w_pixel || (r_state == MOVE);
    assign wrapped = (r_state == MOVE) && (r_obj_x < c_STEP);

endmodule
`default_nettype wire

// File: tb/tb_obstacle_anim_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_obstacle_anim_ctrl
// Description : Scoreboard bench for obstacle_anim_ctrl pixel sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obstacle_anim_ctrl;

    logic       clk;
    logic       resetn;
    logic       go;
    logic       frame_tick;
    logic [6:0] spawn_y;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic [7:0] obj_x;
    logic [6:0] obj_y;
    logic       busy;
    logic       wrapped;

    obstacle_anim_ctrl dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .go         (go),
        .frame_tick (frame_tick),
        .spawn_y    (spawn_y),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .busy       (busy),
        .wrapped    (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int wrap_cnt = 0;
    logic [17:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected pixels {x,y,colour} for one full sprite pass
    task automatic push_pass(input int x0, input int y0, input int col);
        for (int cy = 0; cy < 8; cy++)
            for (int cx = 0; cx < 4; cx++)
                exp_q.push_back({8'(x0 + cx), 7'(y0 + cy), 3'(col)});
    endtask

    // Monitor: every plotted pixel must match the head of the scoreboard
    always @(negedge clk) begin
        if (resetn) begin
            if (wrapped) wrap_cnt++;
            if (plot) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_plot", {x, y, colour}, 0);
                end else begin
                    check("pixel", {x, y, colour}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_quiet(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (busy && n < 300);
        if (n >= 300) check("timeout", n, 0);
    endtask

    task automatic tick_and_wait(output int n);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        n = 1;
        while (busy && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) check("timeout", n, 0);
    endtask

    int n;

    initial begin
        resetn = 1'b0; go = 1'b0; frame_tick = 1'b0; spawn_y = 7'd40;
        repeat (3) step();
        check("rst_plot", plot, 0);
        check("rst_objx", obj_x, 0);
        check("rst_busy", busy, 0);
        check("rst_xy", {x, y, colour}, 0);
        check("rst_wrap", wrapped, 0);

        // First spawn and draw
        resetn = 1'b1;
        step();
        push_pass(156, 40, 2);
        go = 1'b1;
        wait_quiet(n);
        check("spawn_latency", n, 34);
        check("t1_busy", busy, 0);
        check("t1_objx", obj_x, 156);
        check("t1_objy", obj_y, 40);

        // One frame update
        push_pass(156, 40, 0);
        push_pass(155, 40, 2);
        tick_and_wait(n);
        check("update_latency", n, 66);
        check("t2_objx", obj_x, 155);

        // Tick during DRAW is dropped
        push_pass(155, 40, 0);
        push_pass(154, 40, 2);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (40) step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        wait_quiet(n);
        repeat (20) step();
        check("t4_objx", obj_x, 154);
        check("t4_queue", exp_q.size(), 0);
        push_pass(154, 40, 0);
        push_pass(153, 40, 2);
        tick_and_wait(n);
        check("t4_latency", n, 66);
        check("t4_objx2", obj_x, 153);

        // Scroll to the left edge, then wrap with a clamped spawn row
        spawn_y = 7'd127;
        for (int k = 153; k >= 1; k--) begin
            push_pass(k, 40, 0);
            push_pass(k - 1, 40, 2);
            tick_and_wait(n);
        end
        check("t5_objx0", obj_x, 0);
        check("t5_nowrap", wrap_cnt, 0);
        push_pass(0, 40, 0);
        push_pass(156, 112, 2);
        tick_and_wait(n);
        check("wrap_latency", n, 67);
        check("wrap_count", wrap_cnt, 1);
        check("wrap_objx", obj_x, 156);
        check("wrap_objy", obj_y, 112);

        // Asynchronous reset mid-erase
        push_pass(156, 112, 0);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (10) step();
        resetn = 1'b0;
        #1;
        check("async_plot", plot, 0);
        check("async_busy", busy, 0);
        check("async_obj", {obj_x, obj_y}, 0);
        check("async_xy", {x, y, colour}, 0);
        exp_q.delete();
        repeat (2) step();
        spawn_y = 7'd112;
        push_pass(156, 112, 2);
        resetn = 1'b1;
        wait_quiet(n);
        check("respawn_latency", n, 34);
        check("respawn_objy", obj_y, 112);

        // go low in WAIT returns to IDLE and ignores ticks
        go = 1'b0;
        step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (10) step();
        check("idle_busy", busy, 0);
        check("final_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
